// File: rtl/icache_if.sv
// icache_if
// Groups every bus around the instruction-cache controller: the IF-stage
// fetch handshake, the tag-store port, the data-RAM port and the line-refill
// read channel of the memory bus.
//   master : controller side (icache_ctrl)
//   slave  : surroundings (IF stage, tag store, data RAM, memory bus)
interface icache_if;
  // fetch handshake
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  // tag store
  logic [31:0] tag_addr;
  logic        tag_wen;
  logic [20:0] tag_wdata;
  logic        tag_hit;
  logic        tag_valid;
  logic        tag_work;
  // data RAM
  logic [9:0]  data_addr;
  logic        data_wen;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  // refill read channel
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  modport master (
    input  cpu_req, cpu_addr, tag_hit, tag_valid, tag_work, data_rdata,
           mem_rd_ack, mem_rd_valid, mem_rd_data,
    output cpu_addr_ok, cpu_data_ok, cpu_rdata, tag_addr, tag_wen, tag_wdata,
           data_addr, data_wen, data_wdata, mem_rd_req, mem_rd_addr
  );

  modport slave (
    output cpu_req, cpu_addr, tag_hit, tag_valid, tag_work, data_rdata,
           mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  cpu_addr_ok, cpu_data_ok, cpu_rdata, tag_addr, tag_wen, tag_wdata,
           data_addr, data_wen, data_wdata, mem_rd_req, mem_rd_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl
// Direct-mapped instruction-cache controller (128 sets x 8 words).
// Address split: tag = addr[31:12], index = addr[11:5], word = addr[4:2].
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - icache_if.master: fetch handshake, tag-store port, data-RAM port
//          and refill read channel
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | waiting for the tag store to finish its reset sweep
// IDLE     | presenting cpu_addr to tag store / data RAM, accepting
// LOOKUP   | tag/data for req_addr available; hit answers, miss refills
// MISS_REQ | requesting the line from memory until acked
// REFILL   | writing the 8 returned beats, tag written on the last one
// RESP     | returning the captured critical word
module icache_ctrl (
  input logic      clk,
  input logic      rst,
  icache_if.master bus
);
  localparam int LINE_WORDS = 8;
  localparam int INDEX_W    = 7;
  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_RESP
  } state_t;

  state_t              state;
  logic [31:0]         req_addr;
  logic [2:0]          cnt;
  logic [31:0]         crit_word;
  logic [INDEX_W-1:0]  req_index;
  logic                hit;
  logic                beat;

  assign req_index = req_addr[11:5];
  // tag_hit/tag_valid are only meaningful in LOOKUP, one cycle after the
  // address was presented.
  assign hit  = bus.tag_hit && bus.tag_valid;
  assign beat = (state == S_REFILL) && bus.mem_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      req_addr  <= 32'd0;
      cnt       <= 3'd0;
      crit_word <= 32'd0;
    end else begin
      case (state)
        S_INIT: begin
          if (bus.tag_work) state <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.cpu_req) begin
            req_addr <= bus.cpu_addr;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            // a new request accepted alongside the hit keeps the pipe full
            if (bus.cpu_req) req_addr <= bus.cpu_addr;
            else             state    <= S_IDLE;
          end else begin
            state <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (bus.mem_rd_ack) begin
            cnt   <= 3'd0;
            state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.mem_rd_valid) begin
            cnt <= cnt + 3'd1;
            if (cnt == req_addr[4:2]) crit_word <= bus.mem_rd_data;
            if (cnt == LAST_BEAT)     state     <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Outputs decode from the registered state; the accept/hit path and the
  // refill write strobe must react in the same cycle as their inputs.
  always_comb begin
    bus.cpu_addr_ok = 1'b0;
    bus.cpu_data_ok = 1'b0;
    bus.cpu_rdata   = 32'd0;
    bus.tag_addr    = 32'd0;
    bus.tag_wen     = 1'b0;
    bus.tag_wdata   = 21'd0;
    bus.data_addr   = 10'd0;
    bus.data_wen    = 1'b0;
    bus.data_wdata  = 32'd0;
    bus.mem_rd_req  = 1'b0;
    bus.mem_rd_addr = 32'd0;
    case (state)
      S_IDLE: begin
        bus.cpu_addr_ok = bus.cpu_req;
        bus.tag_addr    = bus.cpu_addr;
        bus.data_addr   = bus.cpu_addr[11:2];
      end
      S_LOOKUP: begin
        if (hit) begin
          bus.cpu_data_ok = 1'b1;
          bus.cpu_rdata   = bus.data_rdata;
          bus.cpu_addr_ok = bus.cpu_req;
          bus.tag_addr    = bus.cpu_addr;
          bus.data_addr   = bus.cpu_addr[11:2];
        end else begin
          bus.tag_addr  = req_addr;
          bus.data_addr = req_addr[11:2];
        end
      end
      S_MISS_REQ: begin
        bus.mem_rd_req  = 1'b1;
        bus.mem_rd_addr = {req_addr[31:5], 5'b0};
        bus.tag_addr    = req_addr;
        bus.data_addr   = req_addr[11:2];
      end
      S_REFILL: begin
        bus.tag_addr  = req_addr;
        bus.data_addr = {req_index, cnt};
        if (beat) begin
          bus.data_wen   = 1'b1;
          bus.data_wdata = bus.mem_rd_data;
          // tag goes valid only with the final beat, so an abandoned refill
          // never exposes a partial line
          if (cnt == LAST_BEAT) begin
            bus.tag_wen   = 1'b1;
            bus.tag_wdata = {1'b1, req_addr[31:12]};
          end
        end
      end
      S_RESP: begin
        bus.cpu_data_ok = 1'b1;
        bus.cpu_rdata   = crit_word;
        bus.tag_addr    = req_addr;
        bus.data_addr   = req_addr[11:2];
      end
      default: ;
    endcase
  end
endmodule
